// File: rtl/perf_event_monitor_pkg.sv
// perf_event_monitor_pkg: channel indices, trace record layout and helpers shared by the monitor and its users
package perf_event_monitor_pkg;
  localparam int PEM_NUM_CH = 5;
  localparam int CH_RETIRE = 0;
  localparam int CH_IREQ = 1;
  localparam int CH_IHIT = 2;
  localparam int CH_DREQ = 3;
  localparam int CH_DHIT = 4;
  typedef enum logic [1:0] {
    REC_NONE  = 2'b00,
    REC_REG   = 2'b01,
    REC_STORE = 2'b10,
    REC_LOAD  = 2'b11
  } rec_kind_e;
  typedef struct packed {
    rec_kind_e   kind;
    logic [2:0]  rd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  pad;
  } trace_rec_t;
  localparam int REC_KIND_LSB = 38;
  localparam int REC_REG_LSB = 35;
  localparam int REC_ADDR_LSB = 19;
  localparam int REC_DATA_LSB = 3;
  function automatic trace_rec_t mk_rec(rec_kind_e k, logic [2:0] r, logic [15:0] a, logic [15:0] d);
    mk_rec = '{kind: k, rd: r, addr: a, data: d, pad: 3'b000};
  endfunction
endpackage

// File: rtl/perf_event_monitor_if.sv
// perf_event_monitor_if: control, readback and trace handshake bundle between core side and monitor
interface perf_event_monitor_if
  import perf_event_monitor_pkg::*;
#(
  parameter int NUM_CH = PEM_NUM_CH,
  parameter int CNT_W = 32,
  parameter int REC_W = $bits(trace_rec_t)
);
  logic                        en;
  logic                        clear;
  logic                        halt;
  logic [NUM_CH-1:0]           event_vec;
  logic [$clog2(NUM_CH+1)-1:0] rd_sel;
  logic [CNT_W-1:0]            rd_data;
  logic [NUM_CH-1:0]           ovf_vec;
  logic                        frozen;
  logic                        retire_valid;
  logic [REC_W-1:0]            retire_rec;
  logic                        trc_valid;
  logic [REC_W-1:0]            trc_data;
  logic                        trc_ready;
  logic                        trc_overflow;
  modport master (
    output en, clear, halt, event_vec, rd_sel, retire_valid, retire_rec, trc_ready,
    input  rd_data, ovf_vec, frozen, trc_valid, trc_data, trc_overflow
  );
  modport slave (
    input  en, clear, halt, event_vec, rd_sel, retire_valid, retire_rec, trc_ready,
    output rd_data, ovf_vec, frozen, trc_valid, trc_data, trc_overflow
  );
endinterface

// File: rtl/perf_trace_fifo.sv
// perf_trace_fifo: retire record FIFO with extra-MSB pointers, sync clear and drop-on-full
module perf_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int REC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REC_W-1:0] data_i,
  output logic [REC_W-1:0] data_o,
  output logic             empty_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic full, do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o && !clear_i;
  // a full FIFO still accepts a push when the same cycle frees a slot
  assign do_push = push_i && !clear_i && (!full || do_pop);
  assign drop_o = push_i && !clear_i && full && !do_pop;
  assign data_o = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = clear_i ? '0 : wr_q + (AW+1)'(do_push);
    rd_d = clear_i ? '0 : rd_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: per-channel event counters plus cycle counter, halt freeze and retire trace FIFO
module perf_event_monitor
  import perf_event_monitor_pkg::*;
#(
  parameter int NUM_CH = PEM_NUM_CH,
  parameter int CNT_W = 32,
  parameter int SAT_MODE = 1,
  parameter int DEPTH = 8,
  parameter int REC_W = $bits(trace_rec_t)
) (
  input logic clk,
  input logic rst,
  perf_event_monitor_if.slave bus_io
);
  localparam int SEL_W = $clog2(NUM_CH+1);
  localparam logic [SEL_W-1:0] SEL_CYC = SEL_W'(NUM_CH);
  logic count, push, empty, drop;
  logic [NUM_CH:0] inc, at_max;
  logic [NUM_CH:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic frozen_q, frozen_d, tovf_q, tovf_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  assign count = bus_io.en && !frozen_q && !bus_io.clear;
  // slot NUM_CH is the cycle counter: it ticks on every count cycle
  assign inc = {count, bus_io.event_vec & {NUM_CH{count}}};
  for (genvar c = 0; c <= NUM_CH; c++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign at_max[c] = &cnt_q;
    assign cnt[c] = cnt_q;
    always_comb begin
      cnt_d = bus_io.clear ? '0 : !inc[c] ? cnt_q : !at_max[c] ? cnt_q + 1'b1 : (SAT_MODE != 0) ? cnt_q : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
  end
  assign push = bus_io.retire_valid && !frozen_q && !bus_io.clear;
  perf_trace_fifo #(.DEPTH(DEPTH), .REC_W(REC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus_io.clear),
    .push_i  (push),
    .pop_i   (bus_io.trc_ready),
    .data_i  (bus_io.retire_rec),
    .data_o  (bus_io.trc_data),
    .empty_o (empty),
    .drop_o  (drop)
  );
  always_comb begin
    ovf_d = bus_io.clear ? '0 : ovf_q | (inc[NUM_CH-1:0] & at_max[NUM_CH-1:0]);
    frozen_d = bus_io.clear ? 1'b0 : frozen_q | (count & bus_io.halt);
    tovf_d = bus_io.clear ? 1'b0 : tovf_q | drop;
    rd_d = (bus_io.rd_sel <= SEL_CYC) ? cnt[bus_io.rd_sel] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
      frozen_q <= 1'b0;
      tovf_q <= 1'b0;
      rd_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      frozen_q <= frozen_d;
      tovf_q <= tovf_d;
      rd_q <= rd_d;
    end
  end
  assign bus_io.rd_data = rd_q;
  assign bus_io.ovf_vec = ovf_q;
  assign bus_io.frozen = frozen_q;
  assign bus_io.trc_valid = !empty;
  assign bus_io.trc_overflow = tovf_q;
endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: random and directed stimulus on a 32-bit saturating, 4-bit saturating and 4-bit wrapping monitor
module tb_perf_event_monitor;
  import perf_event_monitor_pkg::*;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  perf_event_monitor_if #(.NUM_CH(5), .CNT_W(32), .REC_W(40)) bus ();
  perf_event_monitor_if #(.NUM_CH(5), .CNT_W(4), .REC_W(40)) sif ();
  perf_event_monitor_if #(.NUM_CH(5), .CNT_W(4), .REC_W(40)) wif ();
  assign sif.en = bus.en;
  assign sif.clear = bus.clear;
  assign sif.halt = bus.halt;
  assign sif.event_vec = bus.event_vec;
  assign sif.rd_sel = bus.rd_sel;
  assign sif.retire_valid = bus.retire_valid;
  assign sif.retire_rec = bus.retire_rec;
  assign sif.trc_ready = bus.trc_ready;
  assign wif.en = bus.en;
  assign wif.clear = bus.clear;
  assign wif.halt = bus.halt;
  assign wif.event_vec = bus.event_vec;
  assign wif.rd_sel = bus.rd_sel;
  assign wif.retire_valid = bus.retire_valid;
  assign wif.retire_rec = bus.retire_rec;
  assign wif.trc_ready = bus.trc_ready;
  perf_event_monitor #(.NUM_CH(5), .CNT_W(32), .SAT_MODE(1), .DEPTH(8), .REC_W(40)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  perf_event_monitor #(.NUM_CH(5), .CNT_W(4), .SAT_MODE(1), .DEPTH(8), .REC_W(40)) dut_s4 (.clk(clk), .rst(rst), .bus_io(sif));
  perf_event_monitor #(.NUM_CH(5), .CNT_W(4), .SAT_MODE(0), .DEPTH(8), .REC_W(40)) dut_w4 (.clk(clk), .rst(rst), .bus_io(wif));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // reference model: index 0 = 32-bit sat, 1 = 4-bit sat, 2 = 4-bit wrap; counter slot 5 is cycles
  longint unsigned MAXV [3] = '{64'hFFFF_FFFF, 64'd15, 64'd15};
  bit SATV [3] = '{1'b1, 1'b1, 1'b0};
  longint unsigned m_cnt [3][6];
  longint unsigned m_rd [3];
  bit [4:0] m_ovf [3];
  bit m_frz, m_tovf;
  logic [39:0] m_q [$];
  logic [39:0] recs [10];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 6; i++) m_cnt[d][i] = 0;
      m_ovf[d] = '0;
    end
    m_frz = 0;
    m_tovf = 0;
    m_q.delete();
  endtask
  task automatic model_reset();
    model_clear();
    for (int d = 0; d < 3; d++) m_rd[d] = 0;
  endtask
  task automatic model_step();
    bit count, push, pop;
    count = bus.en && !m_frz && !bus.clear;
    for (int d = 0; d < 3; d++) m_rd[d] = (bus.rd_sel <= 5) ? m_cnt[d][bus.rd_sel] : 0;
    if (bus.clear) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 6; i++)
        if (count && (i == 5 || bus.event_vec[i])) begin
          if (m_cnt[d][i] == MAXV[d]) begin
            if (!SATV[d]) m_cnt[d][i] = 0;
            if (i < 5) m_ovf[d][i] = 1'b1;
          end else m_cnt[d][i]++;
        end
    push = bus.retire_valid && !m_frz;
    pop = m_q.size() > 0 && bus.trc_ready;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 8) m_q.push_back(bus.retire_rec);
      else m_tovf = 1;
    end
    if (count && bus.halt) m_frz = 1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_data", bus.rd_data, m_rd[0]);
      chk("rd_data_s4", sif.rd_data, m_rd[1]);
      chk("rd_data_w4", wif.rd_data, m_rd[2]);
      chk("ovf_vec", bus.ovf_vec, m_ovf[0]);
      chk("ovf_vec_s4", sif.ovf_vec, m_ovf[1]);
      chk("ovf_vec_w4", wif.ovf_vec, m_ovf[2]);
      chk("frozen", bus.frozen, m_frz);
      chk("trc_valid", bus.trc_valid, m_q.size() != 0);
      chk("trc_overflow", bus.trc_overflow, m_tovf);
      if (m_q.size() != 0) chk("trc_data", bus.trc_data, m_q[0]);
    end
  end
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask
  task automatic idle();
    bus.en = 0;
    bus.clear = 0;
    bus.halt = 0;
    bus.event_vec = '0;
    bus.rd_sel = '0;
    bus.retire_valid = 0;
    bus.retire_rec = '0;
    bus.trc_ready = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  initial begin
    rst = 1;
    idle();
    model_reset();
    for (int k = 0; k < 10; k++) recs[k] = mk_rec(REC_REG, 3'(k), 16'h0100 + 16'(k), 16'hA000 + 16'(k));
    do_reset();
    chk("reset_rd", bus.rd_data, 0);
    chk("reset_valid", bus.trc_valid, 0);
    bus.en = 1;
    bus.event_vec = 5'b00011;
    repeat (10) cyc();
    bus.en = 0;
    bus.event_vec = '0;
    bus.rd_sel = 0;
    cyc();
    chk("t1_ch0", bus.rd_data, 10);
    bus.rd_sel = 1;
    cyc();
    chk("t1_ch1", bus.rd_data, 10);
    bus.rd_sel = 5;
    cyc();
    chk("t1_cycles", bus.rd_data, 10);
    chk("t1_cycles_s4", sif.rd_data, 10);
    do_reset();
    bus.en = 1;
    bus.event_vec = 5'b00001;
    repeat (20) cyc();
    bus.en = 0;
    bus.event_vec = '0;
    bus.rd_sel = 0;
    cyc();
    chk("t2_main", bus.rd_data, 20);
    chk("t2_sat", sif.rd_data, 15);
    chk("t2_wrap", wif.rd_data, 4);
    chk("t2_sat_ovf", sif.ovf_vec, 5'b00001);
    chk("t2_wrap_ovf", wif.ovf_vec, 5'b00001);
    chk("t2_main_ovf", bus.ovf_vec, 0);
    do_reset();
    bus.en = 1;
    bus.event_vec = 5'b00001;
    bus.halt = 1;
    bus.retire_valid = 1;
    bus.retire_rec = recs[0];
    cyc();
    chk("t3_frozen", bus.frozen, 1);
    bus.halt = 0;
    bus.retire_rec = recs[1];
    repeat (5) cyc();
    bus.en = 0;
    bus.event_vec = '0;
    bus.retire_valid = 0;
    bus.rd_sel = 0;
    cyc();
    chk("t3_ch0", bus.rd_data, 1);
    chk("t3_head", bus.trc_data, recs[0]);
    bus.trc_ready = 1;
    cyc();
    chk("t3_one_rec", bus.trc_valid, 0);
    bus.trc_ready = 0;
    bus.clear = 1;
    cyc();
    chk("t3_clr_frozen", bus.frozen, 0);
    chk("t3_clr_rd", bus.rd_data, 1);
    bus.clear = 0;
    cyc();
    chk("t3_after_clr", bus.rd_data, 0);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bus.retire_valid = 1;
      bus.retire_rec = recs[k];
      cyc();
    end
    bus.retire_valid = 0;
    chk("t4_overflow", bus.trc_overflow, 1);
    bus.trc_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("t4_order", bus.trc_data, recs[k]);
      cyc();
    end
    chk("t4_empty", bus.trc_valid, 0);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.retire_valid = 1;
      bus.retire_rec = recs[k];
      cyc();
    end
    chk("t5_no_ovf_full", bus.trc_overflow, 0);
    bus.retire_rec = recs[8];
    bus.trc_ready = 1;
    cyc();
    bus.retire_valid = 0;
    chk("t5_head", bus.trc_data, recs[1]);
    chk("t5_ovf", bus.trc_overflow, 0);
    repeat (7) cyc();
    chk("t5_tail", bus.trc_data, recs[8]);
    do_reset();
    bus.en = 1;
    bus.rd_sel = 5;
    for (int k = 0; k < 5; k++) begin
      bus.retire_valid = 1;
      bus.retire_rec = recs[k];
      cyc();
    end
    bus.retire_valid = 0;
    bus.trc_ready = 1;
    repeat (2) cyc();
    chk("t6_rd_pre", bus.rd_data, 6);
    chk("t6_head_pre", bus.trc_data, recs[2]);
    #2 rst = 1;
    model_reset();
    #1;
    chk("t6_async_valid", bus.trc_valid, 0);
    chk("t6_async_rd", bus.rd_data, 0);
    idle();
    repeat (2) @(negedge clk);
    rst = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.en = $urandom_range(0, 9) < 8;
      bus.clear = $urandom_range(0, 99) < 3;
      bus.halt = $urandom_range(0, 99) < 3;
      bus.event_vec = 5'($urandom);
      bus.rd_sel = 3'($urandom);
      bus.retire_valid = $urandom_range(0, 1) == 1;
      bus.retire_rec = mk_rec(rec_kind_e'($urandom_range(1, 3)), 3'($urandom), 16'($urandom), 16'($urandom));
      bus.trc_ready = $urandom_range(0, 9) < 4;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
